w_ram_reader: RTL
=================

Name: w_ram_reader

Overview:
Downstream consumer of the FFT-result BRAM filled by the writer stage over port A.
- Polls the completion flag word through BRAM port B.
- Once a complete set is flagged, reads every stored 32-bit FFT word back in frame order.
- Streams the words out over a valid/ready handshake, then clears the flag so the writer can start a new set.

Parameters:
FRAME_WORDS, 28, 32-bit words per FFT frame (896-bit frame / 32)
FRAME_STRIDE, 112, byte stride between frames
FLAG_ADDR, 8000, byte address of the completion flag word
POLL_GAP, 1024, idle cycles between flag polls
RD_LAT, 2, BRAM port-B read latency in cycles (1..3)

Ports:
clk  in  1  system clock; also drives clkb
reset  in  1  asynchronous, active-low reset
frame_total  in  6  number of frames in the set (1..56); sampled on flag detect
addrb  out  32  BRAM port-B byte address
clkb  out  1  equals clk
dinb  out  32  BRAM write data (flag clear only)
doutb  in  32  BRAM read data
enb  out  1  BRAM enable
rstb  out  1  tied 0
web  out  4  byte write enables
m_data  out  32  streamed FFT word
m_valid  out  1  m_data valid
m_ready  in  1  consumer accepts
m_frame  out  6  frame index of the current word, 1-based
m_last  out  1  final beat of the set
m_choise  out  3  mode taken from the flag low byte
busy  out  1  high from flag detect until flag cleared

Behaviour:
- Reset values: addrb=0, dinb=0, enb=0, web=0, m_data=0, m_valid=0, m_frame=0, m_last=0, m_choise=0, busy=0; FSM in IDLE; poll counter=0.
- Address map: word k (0..FRAME_WORDS-1) of frame f (1..frame_total) is at FRAME_STRIDE*(f-1)+4*(k+1). Frame 1 occupies 4..112, frame 2 occupies 116..224.
- IDLE: count POLL_GAP cycles, then go to FLAG_RD.
- FLAG_RD: addrb=FLAG_ADDR, enb=1, web=0. Wait RD_LAT cycles, then go to FLAG_CHK.
- FLAG_CHK: the flag is valid when doutb[31:8]==24'hF0F0F0 and doutb[7:0] is in F0..F4.
  - Valid flag: m_choise=doutb[2:0], latch frame_total, busy=1, f=1, k=0.
    - If the latched frame_total is 0 or above 56, go to CLEAR with no beats emitted.
    - Otherwise go to RD_ISSUE.
  - Invalid flag, including 0: enb=0, return to IDLE.
- RD_ISSUE: drive the address for (f,k), enb=1. Wait RD_LAT cycles (RD_WAIT), capture doutb into m_data, assert m_valid, go to OUT.
- OUT:
  - Hold m_data, m_frame and m_last stable while m_valid && !m_ready.
  - On handshake, advance k, wrapping to 0 and incrementing f at FRAME_WORDS.
  - The next read is issued in the cycle after the handshake. m_valid drops in that cycle.
  - m_last=1 only on f==frame_total, k==FRAME_WORDS-1.
  - After the last handshake, go to CLEAR.
- CLEAR: addrb=FLAG_ADDR, dinb=0, web=4'hF, enb=1 for exactly one cycle, then web=0, enb=0, busy=0, IDLE.
- Throughput: one beat per RD_LAT+2 cycles with m_ready held high. No read is issued while a beat is pending.
- Reset mid-operation clears all state immediately. The flag is not cleared, so the set is re-read from frame 1 after the next poll.
- m_ready asserted while m_valid=0 is ignored.
- Frame counter width is 6 bits; f never exceeds the latched frame_total.

Optional Feature:
Macro W_RAM_READER_CHK_EN.
- Defined: after the final data word, one extra beat with m_data = XOR of all streamed words of the set and m_frame=0. m_last moves to this beat; the data word before it has m_last=0.
- Undefined: no extra beat; m_last is on the final data word. The XOR accumulator is not synthesised.

Decomposition:
Shared package w_ram_pkg holds:
- FSM state enum: IDLE, FLAG_RD, FLAG_CHK, RD_ISSUE, RD_WAIT, OUT, CLEAR.
- FLAG_MAGIC=24'hF0F0F0, FLAG_ADDR, FRAME_WORDS, FRAME_STRIDE, MAX_FRAMES=56.

Sub-module w_ram_addr_gen: a combinational plus registered (f,k) to byte-address generator, with wrap and last detection. The writer stage may reuse it.

Test Plan:
1. Flag=0 in BRAM, run 5*POLL_GAP cycles -> only flag reads at address 8000; m_valid never asserts; web stays 0.
2. Flag=F0F0F0F2, frame_total=2, words preloaded as address value, m_ready=1 -> 56 beats with m_data 4,8..112,116..224; m_choise=2; m_last on beat 56; then one write of 0 to 8000.
3. Same set, m_ready toggled 1 cycle on / 3 cycles off -> m_data/m_frame stable while stalled; same 56-beat order; no dropped or duplicated beats.
4. Flag=F0F0F0F7 -> treated as invalid; no beats; flag not cleared; polling continues.
5. Assert reset at beat 30 of a 2-frame set -> outputs return to reset values at once; after release, the next poll restarts at frame 1 word 0 (address 4).
6. W_RAM_READER_CHK_EN defined, frame_total=1, words 1..28 -> 29 beats; beat 29 is m_data=XOR(1..28)=28, m_frame=0, m_last=1.

Source files
------------

// File: rtl/w_ram_pkg.sv
// w_ram_pkg: shared definitions for the FFT-result BRAM reader (and writer).
//   state_t     - reader FSM states
//   FLAG_MAGIC  - upper 24 bits of a valid completion flag word
//   FLAG_ADDR   - byte address of the completion flag word
//   FRAME_WORDS - 32-bit words per FFT frame
//   FRAME_STRIDE- byte stride between frames
//   MAX_FRAMES  - largest frame count a set may carry
//   flag_ok()   - completion-flag validity test
package w_ram_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLAG_RD  = 3'd1,
    FLAG_CHK = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    OUT      = 3'd5,
    CLEAR    = 3'd6
  } state_t;

  localparam logic [23:0] FLAG_MAGIC   = 24'hF0F0F0;
  localparam logic [31:0] FLAG_ADDR    = 32'd8000;
  localparam int          FRAME_WORDS  = 28;
  localparam int          FRAME_STRIDE = 112;
  localparam int          MAX_FRAMES   = 56;

  // Low byte must be F0..F4; its low three bits carry the mode.
  function automatic logic flag_ok(input logic [31:0] w);
    return (w[31:8] == FLAG_MAGIC) && (w[7:3] == 5'b11110) && (w[2:0] <= 3'd4);
  endfunction

endpackage

// File: rtl/w_ram_addr_gen.sv
// w_ram_addr_gen: (frame, word) position tracker and byte-address generator.
//   clk, reset : clock, asynchronous active-low reset
//   start      : load position frame 1 / word 0
//   adv        : step to the next word (wraps word, bumps frame)
//   total      : frame count of the current set
//   f          : current frame index, 1-based
//   last       : current position is the final word of the set
//   addr_nxt   : byte address of the position valid after this clock edge
module w_ram_addr_gen
  import w_ram_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        adv,
  input  logic [5:0]  total,
  output logic [5:0]  f,
  output logic        last,
  output logic [31:0] addr_nxt
);

  localparam int KW = $clog2(FRAME_WORDS);

  logic [KW-1:0] k, k_d;
  logic [5:0]    f_d;

  assign last = (f == total) && (k == KW'(FRAME_WORDS - 1));

  // Advancing past the final word is suppressed so f never exceeds total.
  always_comb begin
    f_d = f;
    k_d = k;
    if (start) begin
      f_d = 6'd1;
      k_d = '0;
    end else if (adv && !last) begin
      if (k == KW'(FRAME_WORDS - 1)) begin
        k_d = '0;
        f_d = f + 6'd1;
      end else begin
        k_d = k + KW'(1);
      end
    end
  end

  // Frame data starts one word past the frame base.
  assign addr_nxt = 32'(FRAME_STRIDE) * (32'(f_d) - 32'd1) + ((32'(k_d) + 32'd1) << 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f <= '0;
      k <= '0;
    end else begin
      f <= f_d;
      k <= k_d;
    end
  end

endmodule

// File: rtl/w_ram_reader.sv
// w_ram_reader: polls the FFT-result completion flag over BRAM port B, streams
// the stored set out on a valid/ready interface, then clears the flag.
//   clk, reset    : clock, asynchronous active-low reset
//   frame_total   : frames in the set, sampled when the flag is detected
//   addrb..web    : BRAM port B (clkb = clk, rstb tied low)
//   m_data/m_valid/m_ready/m_frame/m_last : output stream
//   m_choise      : mode bits from the flag low byte
//   busy          : set from flag detect until the flag has been cleared
// Build option W_RAM_READER_CHK_EN: append one beat carrying the XOR of all
// words of the set (m_frame=0, m_last on that beat).
//
// state    | meaning
// IDLE     | count POLL_GAP cycles between polls
// FLAG_RD  | flag address on port B, waiting RD_LAT cycles
// FLAG_CHK | evaluate flag word, start a set or drop back to IDLE
// RD_ISSUE | data address on port B
// RD_WAIT  | waiting RD_LAT cycles for data, then capture
// OUT      | beat presented, waiting for handshake
// CLEAR    | one-cycle write of zero to the flag word
module w_ram_reader
  import w_ram_pkg::*;
#(
  parameter int POLL_GAP = 1024,
  parameter int RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  frame_total,
  output logic [31:0] addrb,
  output logic        clkb,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  output logic        enb,
  output logic        rstb,
  output logic [3:0]  web,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [5:0]  m_frame,
  output logic        m_last,
  output logic [2:0]  m_choise,
  output logic        busy
);

  localparam int PW = $clog2(POLL_GAP + 1);

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [1:0]    lat_cnt;
  logic [5:0]    total_q;
  logic          gen_start, gen_adv, gen_last;
  logic [5:0]    gen_f;
  logic [31:0]   gen_addr;
  logic          hs;

`ifdef W_RAM_READER_CHK_EN
  logic [31:0] xor_acc;
  logic        chk_beat;
`endif

  assign clkb = clk;
  assign rstb = 1'b0;
  assign hs   = m_valid && m_ready;

  assign gen_start = (state == FLAG_CHK) && flag_ok(doutb);
  assign gen_adv   = (state == OUT) && hs;

  w_ram_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .start    (gen_start),
    .adv      (gen_adv),
    .total    (total_q),
    .f        (gen_f),
    .last     (gen_last),
    .addr_nxt (gen_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      poll_cnt <= '0;
      lat_cnt  <= '0;
      total_q  <= '0;
      addrb    <= '0;
      dinb     <= '0;
      enb      <= 1'b0;
      web      <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_frame  <= '0;
      m_last   <= 1'b0;
      m_choise <= '0;
      busy     <= 1'b0;
`ifdef W_RAM_READER_CHK_EN
      xor_acc  <= '0;
      chk_beat <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (poll_cnt == PW'(POLL_GAP - 1)) begin
            poll_cnt <= '0;
            addrb    <= FLAG_ADDR;
            enb      <= 1'b1;
            web      <= '0;
            lat_cnt  <= 2'(RD_LAT - 1);
            state    <= FLAG_RD;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        FLAG_RD: begin
          if (lat_cnt == 2'd0) state <= FLAG_CHK;
          else                 lat_cnt <= lat_cnt - 2'd1;
        end
        FLAG_CHK: begin
          if (flag_ok(doutb)) begin
            m_choise <= doutb[2:0];
            total_q  <= frame_total;
            busy     <= 1'b1;
`ifdef W_RAM_READER_CHK_EN
            xor_acc  <= '0;
            chk_beat <= 1'b0;
`endif
            if (frame_total == 6'd0 || frame_total > 6'(MAX_FRAMES)) begin
              addrb <= FLAG_ADDR;
              dinb  <= '0;
              web   <= 4'hF;
              enb   <= 1'b1;
              state <= CLEAR;
            end else begin
              addrb <= gen_addr;
              enb   <= 1'b1;
              state <= RD_ISSUE;
            end
          end else begin
            enb   <= 1'b0;
            state <= IDLE;
          end
        end
        RD_ISSUE: begin
          lat_cnt <= 2'(RD_LAT - 1);
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == 2'd0) begin
            m_data  <= doutb;
            m_frame <= gen_f;
`ifdef W_RAM_READER_CHK_EN
            m_last  <= 1'b0;
`else
            m_last  <= gen_last;
`endif
            m_valid <= 1'b1;
            enb     <= 1'b0;
            state   <= OUT;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        OUT: begin
          if (hs) begin
            m_valid <= 1'b0;
`ifdef W_RAM_READER_CHK_EN
            if (chk_beat) begin
              addrb <= FLAG_ADDR;
              dinb  <= '0;
              web   <= 4'hF;
              enb   <= 1'b1;
              state <= CLEAR;
            end else if (gen_last) begin
              // Checksum beat follows the final data word directly.
              m_data   <= xor_acc ^ m_data;
              m_frame  <= '0;
              m_last   <= 1'b1;
              m_valid  <= 1'b1;
              chk_beat <= 1'b1;
            end else begin
              xor_acc <= xor_acc ^ m_data;
              addrb   <= gen_addr;
              enb     <= 1'b1;
              state   <= RD_ISSUE;
            end
`else
            if (gen_last) begin
              addrb <= FLAG_ADDR;
              dinb  <= '0;
              web   <= 4'hF;
              enb   <= 1'b1;
              state <= CLEAR;
            end else begin
              addrb <= gen_addr;
              enb   <= 1'b1;
              state <= RD_ISSUE;
            end
`endif
          end
        end
        CLEAR: begin
          web   <= '0;
          enb   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
